// File: rtl/dose_sched_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dose_sched_pkg
// Shared definitions for the dose alarm scheduler: scan FSM state encoding,
// ROM entry field positions, and the widths of the pill ID and counters.
// Also holds the saturating increment used by the missed-dose counter.
// -----------------------------------------------------------------------------
package dose_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        CMP  = 2'd3
    } sched_state_e;

    // ROM entry layout: [27:24] pillId, [23:16] hour BCD, [15:8] minute BCD,
    // [7] valid, [6:0] reserved
    localparam int ROM_W     = 28;
    localparam int PILL_LSB  = 24;
    localparam int HOUR_LSB  = 16;
    localparam int MIN_LSB   = 8;
    localparam int VALID_BIT = 7;
    localparam int BCD_W     = 8;

    localparam int PILL_W  = 4;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 3;
    localparam int MISS_W  = 8;
    localparam int TIMER_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        if (v == {MISS_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(MISS_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/dose_pending_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dose_pending_fifo
// Queue of due pill IDs, oldest at the head. A push while full is accepted
// only when a pop happens in the same cycle; otherwise the caller treats it
// as a drop. Pop on an empty queue is ignored.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   enqueue request and pill ID
//   i_pop            dequeue the head
//   o_head           pill ID at the head (meaningful when !o_empty)
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module dose_pending_fifo
    import dose_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [PILL_W-1:0] i_data,
    input  logic              i_pop,
    output logic [PILL_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PILL_W-1:0] r_mem_r [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr_r;
    logic [PTR_W-1:0]  r_rd_ptr_r;
    logic [CNT_W-1:0]  r_count_r;
    logic              w_do_push_s;
    logic              w_do_pop_s;

    assign o_empty     = (r_count_r == {CNT_W{1'b0}});
    assign o_full      = (r_count_r == CNT_W'(DEPTH));
    assign w_do_pop_s  = i_pop && !o_empty;
    // A full queue still takes the new entry when the head leaves this cycle
    assign w_do_push_s = i_push && (!o_full || w_do_pop_s);
    assign o_head      = r_mem_r[r_rd_ptr_r];
    assign o_count     = r_count_r;

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_r[i] <= {PILL_W{1'b0}};
            end
            r_wr_ptr_r <= {PTR_W{1'b0}};
            r_rd_ptr_r <= {PTR_W{1'b0}};
            r_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push_s) begin
                r_mem_r[r_wr_ptr_r] <= i_data;
                r_wr_ptr_r          <= r_wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_do_pop_s) begin
                r_rd_ptr_r <= r_rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({w_do_push_s, w_do_pop_s})
                2'b10:   r_count_r <= r_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count_r <= r_count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count_r <= r_count_r;
            endcase
        end
    end

endmodule

// File: rtl/dose_alarm_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dose_alarm_scheduler
// Once per minute, walks the prescription ROM (ADDR -> WAIT -> CMP per entry)
// and queues every valid entry whose BCD hour/minute equals the time captured
// at scan start. The oldest queued dose drives the alarm; it retires on
// acknowledge or is counted as missed after ACK_TIMEOUT_MIN minute ticks.
// Optional macro SNOOZE_EN adds a snooze that mutes the alarm for SNOOZE_MIN
// ticks, at most twice per head dose.
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   enable             run/pause; low aborts a scan and ignores ticks
//   minuteTick         one-cycle pulse per minute
//   timeHHMM           current time, packed BCD {HH,MM}
//   romAddress/romData synchronous ROM, 1-cycle read latency
//   ackPulse           acknowledge the head dose
//   snoozePulse        snooze request (SNOOZE_EN only)
//   alarmActive        due dose pending and not muted
//   alarmPillId        pill ID of the head dose, 0 when empty
//   pendingCount       queue occupancy
//   missedCount        saturating count of timed-out and dropped doses
//   overflow           sticky queue-full drop flag
//   scanBusy           FSM not in IDLE
// -----------------------------------------------------------------------------
module dose_alarm_scheduler
    import dose_sched_pkg::*;
#(
    parameter int ENTRIES         = 16,
    parameter int QDEPTH          = 4,
    parameter int ACK_TIMEOUT_MIN = 30,
    parameter int SNOOZE_MIN      = 5
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enable,
    input  logic              minuteTick,
    input  logic [15:0]       timeHHMM,
    output logic [ADDR_W-1:0] romAddress,
    input  logic [ROM_W-1:0]  romData,
    input  logic              ackPulse,
    input  logic              snoozePulse,
    output logic              alarmActive,
    output logic [PILL_W-1:0] alarmPillId,
    output logic [CNT_W-1:0]  pendingCount,
    output logic [MISS_W-1:0] missedCount,
    output logic              overflow,
    output logic              scanBusy
);
    localparam logic [ADDR_W-1:0]  LAST_IDX     = ADDR_W'(ENTRIES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(ACK_TIMEOUT_MIN - 1);

    sched_state_e      r_state_r;
    sched_state_e      w_state_next_s;
    logic [ADDR_W-1:0] r_idx_r;
    logic [15:0]       r_snap_r;
    logic              r_rescan_r;
    logic              r_busy_r;
    logic              r_alarm_r;
    logic [PILL_W-1:0] r_pill_r;
    logic [MISS_W-1:0] r_missed_r;
    logic              r_overflow_r;
    logic [TIMER_W-1:0] r_timer_r;

    logic              w_start_s;
    logic              w_match_s;
    logic              w_busy_next_s;
    logic              w_tick_s;
    logic              w_ack_pop_s;
    logic              w_timeout_s;
    logic              w_pop_s;
    logic              w_drop_s;
    logic              w_miss_inc_s;
    logic              w_snooze_s;
    logic              w_muted_s;
    logic              w_unused_s;
    logic              w_full_s;
    logic              w_empty_s;
    logic [PILL_W-1:0] w_head_s;
    logic [CNT_W-1:0]  w_count_s;

    dose_pending_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (resetN),
        .i_push  (w_match_s),
        .i_data  (romData[PILL_LSB +: PILL_W]),
        .i_pop   (w_pop_s),
        .o_head  (w_head_s),
        .o_full  (w_full_s),
        .o_empty (w_empty_s),
        .o_count (w_count_s)
    );

    // Ticks only count while the system runs
    assign w_tick_s    = enable && minuteTick;
    assign w_ack_pop_s = ackPulse && !w_empty_s;
    // A snooze in the same cycle restarts the head timer, so no timeout then
    assign w_timeout_s = w_tick_s && !w_empty_s && (r_timer_r == TIMEOUT_LAST) && !w_snooze_s;
    assign w_pop_s     = w_ack_pop_s || w_timeout_s;
    // Acknowledge wins over a coinciding timeout; a drop needs no pop, so the
    // two miss sources never fire together
    assign w_drop_s     = w_match_s && w_full_s && !w_pop_s;
    assign w_miss_inc_s = (w_timeout_s && !w_ack_pop_s) || w_drop_s;

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state_r <= IDLE;
        end else begin
            r_state_r <= w_state_next_s;
        end
    end

    // FSM next-state logic; enable low forces IDLE from any state
    always_comb begin
        w_state_next_s = r_state_r;
        if (!enable) begin
            w_state_next_s = IDLE;
        end else begin
            case (r_state_r)
                IDLE: begin
                    if (minuteTick || r_rescan_r) begin
                        w_state_next_s = ADDR;
                    end else begin
                        w_state_next_s = IDLE;
                    end
                end
                ADDR:    w_state_next_s = WAIT;
                WAIT:    w_state_next_s = CMP;
                CMP: begin
                    if (r_idx_r == LAST_IDX) begin
                        w_state_next_s = IDLE;
                    end else begin
                        w_state_next_s = ADDR;
                    end
                end
                default: w_state_next_s = IDLE;
            endcase
        end
    end

    // FSM output decode: scan start, entry match, next busy flag
    always_comb begin
        w_start_s     = 1'b0;
        w_match_s     = 1'b0;
        w_busy_next_s = (w_state_next_s != IDLE);
        if ((r_state_r == IDLE) && (w_state_next_s == ADDR)) begin
            w_start_s = 1'b1;
        end else begin
            w_start_s = 1'b0;
        end
        // Raw BCD byte equality against the snapshot taken at scan start
        if (enable && (r_state_r == CMP) && romData[VALID_BIT] &&
            (romData[HOUR_LSB +: BCD_W] == r_snap_r[15:8]) &&
            (romData[MIN_LSB +: BCD_W] == r_snap_r[7:0])) begin
            w_match_s = 1'b1;
        end else begin
            w_match_s = 1'b0;
        end
    end

    // Scan datapath: entry index, time snapshot, rescan request, busy flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_idx_r    <= {ADDR_W{1'b0}};
            r_snap_r   <= 16'h0000;
            r_rescan_r <= 1'b0;
            r_busy_r   <= 1'b0;
        end else begin
            r_busy_r <= w_busy_next_s;
            if (w_start_s) begin
                r_snap_r <= timeHHMM;
                r_idx_r  <= {ADDR_W{1'b0}};
            end else if ((r_state_r == CMP) && (w_state_next_s == ADDR)) begin
                r_idx_r <= r_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                r_idx_r <= r_idx_r;
            end
            // A tick arriving mid-scan is remembered and served from IDLE
            if (!enable || w_start_s) begin
                r_rescan_r <= 1'b0;
            end else if (minuteTick && (r_state_r != IDLE)) begin
                r_rescan_r <= 1'b1;
            end else begin
                r_rescan_r <= r_rescan_r;
            end
        end
    end

    // Head timer, missed counter and sticky overflow
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_timer_r    <= {TIMER_W{1'b0}};
            r_missed_r   <= {MISS_W{1'b0}};
            r_overflow_r <= 1'b0;
        end else begin
            if (w_pop_s || w_snooze_s) begin
                r_timer_r <= {TIMER_W{1'b0}};
            end else if (w_tick_s && !w_empty_s) begin
                r_timer_r <= r_timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
            end else begin
                r_timer_r <= r_timer_r;
            end
            if (w_miss_inc_s) begin
                r_missed_r <= sat_inc(r_missed_r);
            end
            if (w_drop_s) begin
                r_overflow_r <= 1'b1;
            end
        end
    end

    // Registered alarm outputs, one cycle behind the queue state
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alarm_r <= 1'b0;
            r_pill_r  <= {PILL_W{1'b0}};
        end else begin
            r_alarm_r <= (w_count_s != {CNT_W{1'b0}}) && !w_muted_s;
            r_pill_r  <= w_empty_s ? {PILL_W{1'b0}} : w_head_s;
        end
    end

`ifdef SNOOZE_EN
    localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_MIN);

    logic       r_muted_r;
    logic [7:0] r_mute_cnt_r;
    logic [1:0] r_snooze_num_r;

    assign w_snooze_s = snoozePulse && !w_empty_s && (r_snooze_num_r < 2'd2);
    assign w_muted_s  = r_muted_r;
    assign w_unused_s = ^romData[6:0];

    // Mute state; any pop starts the next head dose with a fresh snooze budget
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_muted_r      <= 1'b0;
            r_mute_cnt_r   <= 8'd0;
            r_snooze_num_r <= 2'd0;
        end else if (w_pop_s) begin
            r_muted_r      <= 1'b0;
            r_mute_cnt_r   <= 8'd0;
            r_snooze_num_r <= 2'd0;
        end else if (w_snooze_s) begin
            r_muted_r      <= 1'b1;
            r_mute_cnt_r   <= SNOOZE_LOAD;
            r_snooze_num_r <= r_snooze_num_r + 2'd1;
        end else if (w_tick_s && r_muted_r) begin
            if (r_mute_cnt_r <= 8'd1) begin
                r_muted_r    <= 1'b0;
                r_mute_cnt_r <= 8'd0;
            end else begin
                r_mute_cnt_r <= r_mute_cnt_r - 8'd1;
            end
        end
    end
`else
    assign w_snooze_s = 1'b0;
    assign w_muted_s  = 1'b0;
    assign w_unused_s = ^{snoozePulse, romData[6:0]};
`endif

    assign romAddress   = r_idx_r;
    assign alarmActive  = r_alarm_r;
    assign alarmPillId  = r_pill_r;
    assign pendingCount = w_count_s;
    assign missedCount  = r_missed_r;
    assign overflow     = r_overflow_r;
    assign scanBusy     = r_busy_r;

endmodule

// File: tb/tb_dose_alarm_scheduler.sv
`timescale 1ns/1ps
// Directed bench for dose_alarm_scheduler with a behavioural synchronous ROM.
module tb_dose_alarm_scheduler;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        enable = 1'b0;
    logic        minuteTick = 1'b0;
    logic [15:0] timeHHMM = 16'h0000;
    logic [7:0]  romAddress;
    logic [27:0] romData = 28'd0;
    logic        ackPulse = 1'b0;
    logic        snoozePulse = 1'b0;
    logic        alarmActive;
    logic [3:0]  alarmPillId;
    logic [2:0]  pendingCount;
    logic [7:0]  missedCount;
    logic        overflow;
    logic        scanBusy;

    logic [27:0] rom [16];

    int tests_run    = 0;
    int tests_failed = 0;

    dose_alarm_scheduler dut (
        .clk          (clk),
        .resetN       (resetN),
        .enable       (enable),
        .minuteTick   (minuteTick),
        .timeHHMM     (timeHHMM),
        .romAddress   (romAddress),
        .romData      (romData),
        .ackPulse     (ackPulse),
        .snoozePulse  (snoozePulse),
        .alarmActive  (alarmActive),
        .alarmPillId  (alarmPillId),
        .pendingCount (pendingCount),
        .missedCount  (missedCount),
        .overflow     (overflow),
        .scanBusy     (scanBusy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency
    always @(posedge clk) romData <= rom[romAddress[3:0]];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        minuteTick = 1'b1;
        @(negedge clk);
        minuteTick = 1'b0;
    endtask

    task automatic ack();
        ackPulse = 1'b1;
        @(negedge clk);
        ackPulse = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step(2);
        resetN = 1'b1;
        step(1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (scanBusy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, n < 200}, 32'd1);
    endtask

    task automatic rom_basic();
        for (int i = 0; i < 16; i++) rom[i] = 28'd0;
        rom[3] = {4'd5, 8'h08, 8'h30, 1'b1, 7'd0};
        rom[7] = {4'd9, 8'h08, 8'h30, 1'b0, 7'd0};  // invalid entry
        rom[9] = {4'd7, 8'h08, 8'h31, 1'b1, 7'd0};  // other minute
    endtask

    initial begin
        int busy_cycles;
        rom_basic();

        // Reset values
        step(3);
        check("rst_alarm",   {31'd0, alarmActive}, 32'd0);
        check("rst_pill",    {28'd0, alarmPillId}, 32'd0);
        check("rst_pending", {29'd0, pendingCount}, 32'd0);
        check("rst_missed",  {24'd0, missedCount}, 32'd0);
        check("rst_ovf",     {31'd0, overflow}, 32'd0);
        check("rst_busy",    {31'd0, scanBusy}, 32'd0);
        check("rst_addr",    {24'd0, romAddress}, 32'd0);
        resetN = 1'b1;
        enable = 1'b1;
        timeHHMM = 16'h0830;
        step(2);

        // Basic match and scan length
        tick();
        busy_cycles = 0;
        while (scanBusy && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("scan_len", busy_cycles, 32'd48);
        step(2);
        check("match_alarm",   {31'd0, alarmActive}, 32'd1);
        check("match_pill",    {28'd0, alarmPillId}, 32'd5);
        check("match_pending", {29'd0, pendingCount}, 32'd1);
        check("match_missed",  {24'd0, missedCount}, 32'd0);
`ifndef SNOOZE_EN
        snoozePulse = 1'b1;
        @(negedge clk);
        snoozePulse = 1'b0;
        step(2);
        check("snooze_ignored", {31'd0, alarmActive}, 32'd1);
`endif

        // Acknowledge
        ack();
        check("ack_pending", {29'd0, pendingCount}, 32'd0);
        step(2);
        check("ack_alarm",  {31'd0, alarmActive}, 32'd0);
        check("ack_pill",   {28'd0, alarmPillId}, 32'd0);
        check("ack_missed", {24'd0, missedCount}, 32'd0);
        ack();
        step(2);
        check("ack_empty_pending", {29'd0, pendingCount}, 32'd0);
        check("ack_empty_missed",  {24'd0, missedCount}, 32'd0);

        // Timeout after 30 unacknowledged ticks
        do_reset();
        timeHHMM = 16'h0830;
        tick();
        wait_idle("to_scan");
        timeHHMM = 16'h0845;
        for (int i = 0; i < 29; i++) begin
            tick();
            step(58);
        end
        check("to_29_pending", {29'd0, pendingCount}, 32'd1);
        check("to_29_missed",  {24'd0, missedCount}, 32'd0);
        tick();
        step(2);
        check("to_pending", {29'd0, pendingCount}, 32'd0);
        check("to_missed",  {24'd0, missedCount}, 32'd1);
        check("to_pill",    {28'd0, alarmPillId}, 32'd0);
        check("to_alarm",   {31'd0, alarmActive}, 32'd0);

        // Acknowledge coinciding with the 30th tick
        do_reset();
        timeHHMM = 16'h0830;
        tick();
        wait_idle("col_scan");
        timeHHMM = 16'h0845;
        for (int i = 0; i < 29; i++) begin
            tick();
            step(58);
        end
        minuteTick = 1'b1;
        ackPulse = 1'b1;
        @(negedge clk);
        minuteTick = 1'b0;
        ackPulse = 1'b0;
        step(60);
        check("col_pending", {29'd0, pendingCount}, 32'd0);
        check("col_missed",  {24'd0, missedCount}, 32'd0);

        // Snapshot and rescan: the first scan compares against 08:30 even
        // though the clock moves on; a tick mid-scan forces another scan
        do_reset();
        timeHHMM = 16'h0830;
        tick();
        timeHHMM = 16'h0900;
        step(18);
        tick();
        wait_idle("rs_scan1");
        step(1);
        check("rs_restart", {31'd0, scanBusy}, 32'd1);
        wait_idle("rs_scan2");
        check("rs_pending", {29'd0, pendingCount}, 32'd1);

        // Overflow: six due doses, four slots
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 28'd0;
        for (int i = 0; i < 6; i++) rom[i] = {4'(i + 1), 8'h12, 8'h00, 1'b1, 7'd0};
        timeHHMM = 16'h1200;
        tick();
        wait_idle("ovf_scan");
        step(2);
        check("ovf_pending", {29'd0, pendingCount}, 32'd4);
        check("ovf_flag",    {31'd0, overflow}, 32'd1);
        check("ovf_missed",  {24'd0, missedCount}, 32'd2);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_order%0d", i), {28'd0, alarmPillId}, i);
            ack();
            step(1);
        end
        check("ovf_drained", {29'd0, pendingCount}, 32'd0);
        check("ovf_sticky",  {31'd0, overflow}, 32'd1);

        // Enable dropped during a scan, before entry 3 is compared
        do_reset();
        rom_basic();
        timeHHMM = 16'h0830;
        tick();
        step(8);
        enable = 1'b0;
        step(3);
        check("abort_busy", {31'd0, scanBusy}, 32'd0);
        step(60);
        check("abort_pending", {29'd0, pendingCount}, 32'd0);
        tick();
        step(2);
        check("dis_tick_busy", {31'd0, scanBusy}, 32'd0);
        enable = 1'b1;
        step(5);
        check("reen_busy",    {31'd0, scanBusy}, 32'd0);
        check("reen_pending", {29'd0, pendingCount}, 32'd0);

        // Reset asserted mid-scan with a dose pending
        tick();
        step(20);
        check("pre_rst_pending", {29'd0, pendingCount}, 32'd1);
        resetN = 1'b0;
        #1;
        check("mid_rst_alarm",   {31'd0, alarmActive}, 32'd0);
        check("mid_rst_pill",    {28'd0, alarmPillId}, 32'd0);
        check("mid_rst_pending", {29'd0, pendingCount}, 32'd0);
        check("mid_rst_busy",    {31'd0, scanBusy}, 32'd0);
        check("mid_rst_addr",    {24'd0, romAddress}, 32'd0);
        check("mid_rst_missed",  {24'd0, missedCount}, 32'd0);
        check("mid_rst_ovf",     {31'd0, overflow}, 32'd0);
        step(1);
        resetN = 1'b1;
        step(1);

`ifdef SNOOZE_EN
        // Snooze mutes for five ticks
        timeHHMM = 16'h0830;
        tick();
        wait_idle("sn_scan");
        step(2);
        check("sn_alarm_before", {31'd0, alarmActive}, 32'd1);
        snoozePulse = 1'b1;
        @(negedge clk);
        snoozePulse = 1'b0;
        step(2);
        check("sn_muted", {31'd0, alarmActive}, 32'd0);
        timeHHMM = 16'h0845;
        for (int i = 0; i < 4; i++) begin
            tick();
            step(58);
        end
        check("sn_still_muted", {31'd0, alarmActive}, 32'd0);
        check("sn_pending",     {29'd0, pendingCount}, 32'd1);
        tick();
        step(3);
        check("sn_alarm_back", {31'd0, alarmActive}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dose_alarm_scheduler.md
Name: dose_alarm_scheduler

Overview:
- Sequences the prescription ROM once per minute and compares every dose entry against the running clock.
- Queues due doses, raises the alarm and presents the pill ID of the oldest due dose.
- Retires a dose on user acknowledge, or counts it as missed after a timeout.
- Sits between the Clock, ROM and Control blocks; it owns the ROM address bus while scanning.

Parameters:
- ENTRIES, 16: number of ROM dose entries scanned, addresses 0..ENTRIES-1.
- QDEPTH, 4: pending-dose queue depth (power of two).
- ACK_TIMEOUT_MIN, 30: number of minute ticks the head dose may stay unacknowledged before it is declared missed.
- SNOOZE_MIN, 5: number of minute ticks the alarm stays muted after a snooze (SNOOZE_EN only).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  high while the system runs; low pauses scheduling.
- minuteTick  in  1  one-cycle pulse at each minute rollover.
- timeHHMM  in  16  current time as packed BCD {HH,MM}.
- romAddress  out  8  ROM address; the ROM is synchronous with 1-cycle read latency.
- romData  in  28  ROM entry: [27:24] pillId, [23:16] hour BCD, [15:8] minute BCD, [7] valid, [6:0] reserved.
- ackPulse  in  1  shaped one-cycle acknowledge of the head dose.
- snoozePulse  in  1  shaped one-cycle snooze request.
- alarmActive  out  1  a due dose is pending and not muted.
- alarmPillId  out  4  pillId of the head dose; 0 when the queue is empty.
- pendingCount  out  3  number of queue entries, 0..QDEPTH.
- missedCount  out  8  missed doses, saturating at 255.
- overflow  out  1  sticky; set when a due dose is dropped because the queue is full.
- scanBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, romAddress 0, FSM in IDLE, queue empty, head timer 0.
- FSM states: IDLE, ADDR, WAIT, CMP.
- IDLE -> ADDR when enable && (minuteTick || rescanPending). On this transition:
  - timeHHMM is latched into timeSnap.
  - idx is cleared to 0.
  - rescanPending is cleared.
- ADDR: drive romAddress = idx, then go to WAIT.
- WAIT: romData is valid on the next edge; go to CMP.
- CMP: a match means valid && hour == timeSnap[15:8] && minute == timeSnap[7:0].
  - On a match, push pillId into the queue.
  - If idx == ENTRIES-1, go to IDLE; otherwise idx++ and go to ADDR.
- Scan timing: exactly 3 cycles per entry, so 3*ENTRIES cycles per scan.
- Comparison is a raw 8-bit BCD equality; there is no binary conversion.
- minuteTick during a scan sets rescanPending. The active scan completes on its own snapshot, then a new scan starts from IDLE.
- Push when the queue is full: the pillId is dropped, overflow is set, and missedCount increments.
- Push and pop in the same cycle are both performed; pendingCount is unchanged.
- Head timer:
  - Increments on minuteTick while the queue is non-empty and enable is high.
  - Clears on every pop.
  - When it reaches ACK_TIMEOUT_MIN, the head is popped and missedCount increments.
- ackPulse with a non-empty queue pops the head; missedCount does not change.
- ackPulse with an empty queue is ignored.
- ackPulse and timeout in the same cycle: the acknowledge wins; there is a single pop and no miss.
- alarmActive = (pendingCount != 0) && !muted. It is registered, so it appears 1 cycle after the push.
- enable low:
  - Any scan is aborted and the FSM returns to IDLE; rescanPending is cleared.
  - Queue, counters and overflow are held.
  - Ticks are ignored.
  - ackPulse is still honoured.
- resetN asserted mid-scan or mid-alarm: immediate return to the reset values.

Optional Feature:
- Macro: SNOOZE_EN.
- With SNOOZE_EN defined:
  - snoozePulse with a non-empty queue sets muted and loads a mute counter with SNOOZE_MIN.
  - It also clears the head timer.
  - The mute counter decrements on minuteTick; muted clears at 0 or on any pop.
  - At most 2 snoozes are allowed per head dose; further snoozes are ignored.
- Without SNOOZE_EN: snoozePulse is ignored, muted is constantly 0, and no snooze logic is synthesized.

Decomposition:
- Package dose_sched_pkg holds:
  - The state enum (IDLE/ADDR/WAIT/CMP).
  - Entry field bit positions and widths.
  - The pill ID width (4) and counter widths.
- Sub-module dose_pending_fifo holds the queue: QDEPTH x 4-bit storage with push/pop/full/empty/count.

Test Plan:
- Basic match: entry 3 = {pill 5, 08h, 30m, valid}; timeHHMM = 16'h0830, tick → push after the entry-3 CMP; alarmActive = 1, alarmPillId = 5, pendingCount = 1, scanBusy high for 48 cycles.
- Acknowledge: after the match above, send ackPulse → pendingCount = 0, alarmActive = 0 the next cycle, missedCount stays 0.
- Timeout: after the match, send 30 minute ticks with no acknowledge → head popped, missedCount = 1, alarmPillId = 0.
- Overflow: 6 valid entries at 12:00, tick at 16'h1200 → pendingCount = 4, overflow = 1, missedCount = 2, and the first 4 pill IDs pop in ROM order.
- Ack/timeout collision: ackPulse coincides with the 30th tick → a single pop, missedCount = 0.
- Abort and reset: deassert enable at cycle 10 of a scan → IDLE with no push. Separately, drop resetN mid-scan → all outputs 0 on the next sample. With SNOOZE_EN: snooze, then 5 ticks → alarmActive returns to 1.
